imem_ctrl: RTL and testbench

IMEM_CTRL -- requirements
Module: imem_ctrl

---
 rtl/cpu_pkg.sv | 18 +
 rtl/imem_ram.sv | 25 ++
 rtl/imem_ctrl.sv | 108 ++++++++++
 tb/tb_imem_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, fixed instruction words and the
// instruction-memory controller state encoding (also used by the core decoder).
package cpu_pkg;

    localparam logic [4:0]  OP_NOP    = 5'b00001;
    localparam logic [4:0]  OP_HALT   = 5'b11011;

    localparam logic [15:0] NOP_WORD  = 16'h0800;
    localparam logic [15:0] HALT_WORD = 16'hD800;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: 2^AW x DW, synchronous write, asynchronous read.
// Deliberately has no reset so contents survive controller resets.
module imem_ram #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: loads a program word stream, then serves
// mem[pc] to the core until a HALT opcode. Optional executed-cycle counter
// enabled by macro INSTR_CNT_EN.
module imem_ctrl
    import cpu_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    output logic [DW-1:0] instr,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic [AW:0]   ld_count,
    output logic          run,
`ifdef INSTR_CNT_EN
    output logic [15:0]   icount,
`endif
    output logic          halted
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    imem_state_t   state, state_next;
    logic          accept;
    logic          last_word;
    logic          load_begin;
    logic          in_range;
    logic [DW-1:0] rdata;
    logic [DW-1:0] word;

    imem_ram #(.AW(AW), .DW(DW)) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (ld_count[AW-1:0]),
        .wdata (ld_data),
        .raddr (pc),
        .rdata (rdata)
    );

    assign ld_ready   = (state == ST_LOAD) && (ld_count < DEPTH);
    assign accept     = ld_valid && ld_ready;
    assign last_word  = ld_last || (ld_count == DEPTH - 1'b1);
    assign load_begin = ((state == ST_IDLE) || (state == ST_HALT)) && ld_start;
    assign in_range   = {1'b0, pc} < ld_count;
    assign run        = (state == ST_RUN);
    assign halted     = (state == ST_HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        word       = DW'(NOP_WORD);
        case (state)
            ST_IDLE: begin
                if (ld_start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (accept && last_word) state_next = ST_RUN;
            end
            ST_RUN: begin
                // Fetches past the loaded image read as HALT so a runaway pc stops the core
                word = in_range ? rdata : DW'(HALT_WORD);
                if (word[DW-1 -: 5] == OP_HALT) state_next = ST_HALT;
            end
            ST_HALT: begin
                if (ld_start) state_next = ST_LOAD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign instr = word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_count <= '0;
        end else if (load_begin) begin
            ld_count <= '0;
        end else if (accept) begin
            ld_count <= ld_count + 1'b1;
        end
    end

`ifdef INSTR_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            icount <= '0;
        end else if (load_begin) begin
            icount <= '0;
        end else if ((state == ST_RUN) && (icount != 16'hFFFF)) begin
            icount <= icount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// Scoreboard bench for imem_ctrl: stimulus queues expectations, a negedge
// monitor pops and compares them against the live outputs.
module tb_imem_ctrl;

    localparam int AW = 8;
    localparam int DW = 16;

    localparam int SEL_INSTR  = 0;
    localparam int SEL_COUNT  = 1;
    localparam int SEL_RUN    = 2;
    localparam int SEL_HALTED = 3;
    localparam int SEL_READY  = 4;
    localparam int SEL_ICOUNT = 5;

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic          ld_start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic [AW:0]   ld_count;
    logic          run;
    logic          halted;
`ifdef INSTR_CNT_EN
    logic [15:0]   icount;
`endif

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    imem_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .pc       (pc),
        .instr    (instr),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_count (ld_count),
        .run      (run),
`ifdef INSTR_CNT_EN
        .icount   (icount),
`endif
        .halted   (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SEL_INSTR:  return 32'(instr);
            SEL_COUNT:  return 32'(ld_count);
            SEL_RUN:    return 32'(run);
            SEL_HALTED: return 32'(halted);
            SEL_READY:  return 32'(ld_ready);
`ifdef INSTR_CNT_EN
            SEL_ICOUNT: return 32'(icount);
`endif
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.sel);
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h at %0t", e.name, a, e.val, $time);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [31:0] val, input string name);
        exp_t e;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [DW-1:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] prog3 [3];
        logic [DW-1:0] prog5 [5];
        prog3 = '{16'h8823, 16'h0800, 16'h9905};
        prog5 = '{16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'hD800};

        reset    = 1'b0;
        pc       = '0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        tick();
        tick();
        expect_val(SEL_RUN,    0,       "rst_run");
        expect_val(SEL_HALTED, 0,       "rst_halted");
        expect_val(SEL_COUNT,  0,       "rst_count");
        expect_val(SEL_READY,  0,       "rst_ready");
        expect_val(SEL_INSTR,  16'h0800, "rst_instr");
`ifdef INSTR_CNT_EN
        expect_val(SEL_ICOUNT, 0,       "rst_icount");
`endif
        tick();
        reset = 1'b1;
        tick();

        // Start with a coincident word: must be dropped
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 16'hBEEF;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        expect_val(SEL_COUNT, 0,        "idle_drop_count");
        expect_val(SEL_READY, 1,        "load_ready");
        expect_val(SEL_INSTR, 16'h0800, "load_instr_nop");
        expect_val(SEL_RUN,   0,        "load_run");

        for (int i = 0; i < 3; i++) load_word(prog3[i], i == 2);
        expect_val(SEL_RUN,   1, "p3_run");
        expect_val(SEL_COUNT, 3, "p3_count");
        expect_val(SEL_READY, 0, "p3_ready");
        for (int i = 0; i < 3; i++) begin
            pc = AW'(i);
            ld_start = (i == 1);
            #1;
            expect_val(SEL_INSTR, 32'(prog3[i]), $sformatf("p3_fetch%0d", i));
            tick();
            ld_start = 1'b0;
        end
        expect_val(SEL_RUN, 1, "run_ignores_start");
        pc = 8'd3;
        #1;
        expect_val(SEL_INSTR, 16'hD800, "past_end_halt_word");
        tick();
        expect_val(SEL_HALTED, 1,        "halt_halted");
        expect_val(SEL_RUN,    0,        "halt_run");
        expect_val(SEL_INSTR,  16'h0800, "halt_instr_nop");
        tick();

        // Reload from HALT with a full 256-word image
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        expect_val(SEL_HALTED, 0, "reload_halted_clear");
        expect_val(SEL_COUNT,  0, "reload_count_clear");
        expect_val(SEL_READY,  1, "reload_ready");
        for (int i = 0; i < 256; i++) begin
            ld_valid = 1'b1;
            ld_data  = {8'h12, 8'(i)};
            tick();
        end
        ld_data = 16'hFFFF;
        expect_val(SEL_READY, 0,   "full_ready");
        expect_val(SEL_COUNT, 256, "full_count");
        expect_val(SEL_RUN,   1,   "full_run");
        tick();
        ld_valid = 1'b0;
        pc = 8'd0;
        #1;
        expect_val(SEL_COUNT, 256,      "extra_word_ignored");
        expect_val(SEL_INSTR, 16'h1200, "full_fetch0");
        tick();
        pc = 8'd255;
        #1;
        expect_val(SEL_INSTR, 16'h12FF, "full_fetch255");
        tick();

        // Asynchronous reset in RUN
        reset = 1'b0;
        #1;
        expect_val(SEL_RUN,   0,        "async_rst_run");
        expect_val(SEL_INSTR, 16'h0800, "async_rst_instr");
        expect_val(SEL_COUNT, 0,        "async_rst_count");
        tick();
        reset = 1'b1;
        pc = 8'd0;
        tick();

        // Reset mid-load
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        load_word(16'hAAAA, 1'b0);
        load_word(16'hAAAB, 1'b0);
        expect_val(SEL_COUNT, 2, "mid_load_count");
        tick();
        reset = 1'b0;
        #1;
        expect_val(SEL_COUNT, 0, "mid_load_rst_count");
        expect_val(SEL_READY, 0, "mid_load_rst_ready");
        tick();
        reset = 1'b1;
        tick();
        expect_val(SEL_READY, 0, "idle_after_rst_ready");
        tick();

        // 5-word program ending in HALT
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 5; i++) load_word(prog5[i], i == 4);
        for (int i = 0; i < 5; i++) begin
            pc = AW'(i);
            #1;
            expect_val(SEL_INSTR, 32'(prog5[i]), $sformatf("p5_fetch%0d", i));
            tick();
        end
        expect_val(SEL_HALTED, 1, "p5_halted");
`ifdef INSTR_CNT_EN
        expect_val(SEL_ICOUNT, 5, "p5_icount");
`endif
        tick();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        expect_val(SEL_COUNT, 0, "p5_reload_count");
`ifdef INSTR_CNT_EN
        expect_val(SEL_ICOUNT, 0, "p5_reload_icount");
`endif
        tick();
        tick();

        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
